// File: rtl/uart_boot_loader_if.sv
// Memory write bus between the boot loader (master) and the target memory (slave).
//   o_Mem_Addr : word address of the current write
//   o_Mem_Data : 32-bit data word
//   o_Mem_We   : write request, held until acknowledged
//   i_Mem_Ack  : write acknowledge from memory
interface uart_boot_loader_if #(
   parameter int unsigned ADDR_W = 27
);
   logic [ADDR_W-1:0] o_Mem_Addr;
   logic [31:0]       o_Mem_Data;
   logic              o_Mem_We;
   logic              i_Mem_Ack;

   modport master (
      output o_Mem_Addr,
      output o_Mem_Data,
      output o_Mem_We,
      input  i_Mem_Ack
   );

   modport slave (
      input  o_Mem_Addr,
      input  o_Mem_Data,
      input  o_Mem_We,
      output i_Mem_Ack
   );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a big-endian 32-bit word count followed by that
// many big-endian 32-bit words, writes them to consecutive memory word
// addresses starting at BASE_ADDR and keeps a running 32-bit checksum.
//   i_Clock, reset  : clock, synchronous active-high reset
//   i_Rx_DV/i_Rx_Byte : byte strobe and data from the UART receiver
//   i_Start         : arm request (honoured in IDLE, DONE, ERROR)
//   mem             : memory write bus (master side)
//   o_Busy          : loading in progress (LEN, DATA, WRITE)
//   o_Done          : one-cycle completion pulse
//   o_Error         : sticky overrun flag
//   o_Checksum      : modulo-2^32 sum of written words
module uart_boot_loader #(
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned ADDR_W    = 27
) (
   input  logic                      i_Clock,
   input  logic                      reset,
   input  logic                      i_Rx_DV,
   input  logic [7:0]                i_Rx_Byte,
   input  logic                      i_Start,
   uart_boot_loader_if.master        mem,
   output logic                      o_Busy,
   output logic                      o_Done,
   output logic                      o_Error,
   output logic [31:0]               o_Checksum
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       len_q, len_d;        // length during LEN, remaining words afterwards
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       sum_q, sum_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              arm_c;
   logic              last_byte_c;
   logic [31:0]       len_full_c;

   assign arm_c       = i_Start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   assign last_byte_c = i_Rx_DV && (cnt_q == 2'd3);
   assign len_full_c  = {len_q[23:0], i_Rx_Byte};

   // State register
   always_ff @(posedge i_Clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (arm_c) state_d = S_LEN;
         S_LEN:   if (last_byte_c) state_d = (len_full_c == 32'd0) ? S_DONE : S_DATA;
         S_DATA:  if (last_byte_c) state_d = S_WRITE;
         // Overrun wins over a simultaneous ack
         S_WRITE: begin
            if (i_Rx_DV)        state_d = S_ERROR;
            else if (i_Ack_c()) state_d = (len_q == 32'd1) ? S_DONE : S_DATA;
         end
         S_DONE:  state_d = arm_c ? S_LEN : S_IDLE;
         S_ERROR: if (arm_c) state_d = S_LEN;
         default: state_d = S_IDLE;
      endcase
   end

   function automatic logic i_Ack_c();
      return mem.i_Mem_Ack && we_q;
   endfunction

   // Datapath and output next values
   always_comb begin
      cnt_d  = cnt_q;
      len_d  = len_q;
      data_d = data_q;
      addr_d = addr_q;
      sum_d  = sum_q;
      err_d  = err_q;

      if (arm_c) begin
         cnt_d  = 2'd0;
         len_d  = 32'd0;
         addr_d = BASE;
         sum_d  = 32'd0;
         err_d  = 1'b0;
      end

      unique case (state_q)
         S_LEN: if (i_Rx_DV) begin
            len_d = len_full_c;
            cnt_d = cnt_q + 2'd1;
         end
         S_DATA: if (i_Rx_DV) begin
            data_d = {data_q[23:0], i_Rx_Byte};
            cnt_d  = cnt_q + 2'd1;
         end
         S_WRITE: begin
            if (i_Rx_DV) begin
               err_d = 1'b1;
            end else if (i_Ack_c()) begin
               sum_d  = sum_q + data_q;
               addr_d = addr_q + ADDR_W'(1);
               len_d  = len_q - 32'd1;
               cnt_d  = 2'd0;
            end
         end
         default: ;
      endcase

      we_d   = (state_d == S_WRITE);
      busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
      done_d = (state_d == S_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge i_Clock) begin
      if (reset) begin
         cnt_q  <= 2'd0;
         len_q  <= 32'd0;
         data_q <= 32'd0;
         addr_q <= BASE;
         sum_q  <= 32'd0;
         we_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         len_q  <= len_d;
         data_q <= data_d;
         addr_q <= addr_d;
         sum_q  <= sum_d;
         we_q   <= we_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign mem.o_Mem_Addr = addr_q;
   assign mem.o_Mem_Data = data_q;
   assign mem.o_Mem_We   = we_q;
   assign o_Busy         = busy_q;
   assign o_Done         = done_q;
   assign o_Error        = err_q;
   assign o_Checksum     = sum_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed test of uart_boot_loader: two instances share stimulus, one with
// BASE_ADDR=0 and one with BASE_ADDR=2^27-1 for the address wrap case.
module tb_uart_boot_loader;

   logic        i_Clock = 1'b0;
   logic        reset   = 1'b1;
   logic        rx_dv   = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        start   = 1'b0;
   logic        ack     = 1'b0;

   logic        busy0, done0, err0;
   logic [31:0] sum0;
   logic        busy1, done1, err1;
   logic [31:0] sum1;

   int n_tests = 0;
   int n_fail  = 0;

   uart_boot_loader_if #(.ADDR_W(27)) mem0 ();
   uart_boot_loader_if #(.ADDR_W(27)) mem1 ();

   assign mem0.i_Mem_Ack = ack;
   assign mem1.i_Mem_Ack = ack;

   uart_boot_loader #(.BASE_ADDR(0), .ADDR_W(27)) dut0 (
      .i_Clock    (i_Clock),
      .reset      (reset),
      .i_Rx_DV    (rx_dv),
      .i_Rx_Byte  (rx_byte),
      .i_Start    (start),
      .mem        (mem0),
      .o_Busy     (busy0),
      .o_Done     (done0),
      .o_Error    (err0),
      .o_Checksum (sum0)
   );

   uart_boot_loader #(.BASE_ADDR(32'h07FF_FFFF), .ADDR_W(27)) dut1 (
      .i_Clock    (i_Clock),
      .reset      (reset),
      .i_Rx_DV    (rx_dv),
      .i_Rx_Byte  (rx_byte),
      .i_Start    (start),
      .mem        (mem1),
      .o_Busy     (busy1),
      .o_Done     (done1),
      .o_Error    (err1),
      .o_Checksum (sum1)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_dv   = 1'b1;
      rx_byte = b;
      tick();
      rx_dv   = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_tests++;
      if ({mem0.o_Mem_We, busy0, done0, err0} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000", {mem0.o_Mem_We, busy0, done0, err0});
      end
      n_tests++;
      if (sum0 !== 32'h0 || mem0.o_Mem_Data !== 32'h0 || mem0.o_Mem_Addr !== 27'h0) begin
         n_fail++;
         $display("FAIL reset_values: sum %h data %h addr %h expected 0 0 0", sum0, mem0.o_Mem_Data, mem0.o_Mem_Addr);
      end
      n_tests++;
      if (mem1.o_Mem_Addr !== 27'h7FF_FFFF) begin
         n_fail++;
         $display("FAIL reset_base_addr: got %h expected 7ffffff", mem1.o_Mem_Addr);
      end
   endtask

   task automatic test_two_words();
      // Bytes in IDLE are ignored
      send_byte(8'hA5);
      n_tests++;
      if (busy0 !== 1'b0 || mem0.o_Mem_Data !== 32'h0) begin
         n_fail++;
         $display("FAIL idle_rx_ignored: busy %b data %h expected 0 0", busy0, mem0.o_Mem_Data);
      end
      pulse_start();
      n_tests++;
      if (busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL start_busy: got %b expected 1", busy0);
      end
      send_word(32'h0000_0002);
      send_byte(8'h11);
      send_byte(8'h22);
      // Start during DATA must not disturb assembly
      pulse_start();
      send_byte(8'h33);
      send_byte(8'h44);
      n_tests++;
      if (mem0.o_Mem_We !== 1'b1 || mem0.o_Mem_Addr !== 27'h0 || mem0.o_Mem_Data !== 32'h1122_3344) begin
         n_fail++;
         $display("FAIL write0: we %b addr %h data %h expected 1 0 11223344", mem0.o_Mem_We, mem0.o_Mem_Addr, mem0.o_Mem_Data);
      end
      tick();
      n_tests++;
      if (mem0.o_Mem_We !== 1'b1 || mem0.o_Mem_Data !== 32'h1122_3344) begin
         n_fail++;
         $display("FAIL write0_hold: we %b data %h expected 1 11223344", mem0.o_Mem_We, mem0.o_Mem_Data);
      end
      do_ack();
      n_tests++;
      if (mem0.o_Mem_We !== 1'b0 || sum0 !== 32'h1122_3344 || busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL ack0: we %b sum %h busy %b expected 0 11223344 1", mem0.o_Mem_We, sum0, busy0);
      end
      send_word(32'h5566_7788);
      n_tests++;
      if (mem0.o_Mem_We !== 1'b1 || mem0.o_Mem_Addr !== 27'h1 || mem0.o_Mem_Data !== 32'h5566_7788) begin
         n_fail++;
         $display("FAIL write1: we %b addr %h data %h expected 1 1 55667788", mem0.o_Mem_We, mem0.o_Mem_Addr, mem0.o_Mem_Data);
      end
      tick();
      do_ack();
      n_tests++;
      if (done0 !== 1'b1 || sum0 !== 32'h6688_AACC || busy0 !== 1'b0 || mem0.o_Mem_We !== 1'b0) begin
         n_fail++;
         $display("FAIL done_two: done %b sum %h busy %b we %b expected 1 6688aacc 0 0", done0, sum0, busy0, mem0.o_Mem_We);
      end
      tick();
      n_tests++;
      if (done0 !== 1'b0 || sum0 !== 32'h6688_AACC) begin
         n_fail++;
         $display("FAIL done_pulse_end: done %b sum %h expected 0 6688aacc", done0, sum0);
      end
   endtask

   task automatic test_zero_len();
      pulse_start();
      n_tests++;
      if (sum0 !== 32'h0) begin
         n_fail++;
         $display("FAIL start_clears_sum: got %h expected 0", sum0);
      end
      send_word(32'h0000_0000);
      n_tests++;
      if (done0 !== 1'b1 || mem0.o_Mem_We !== 1'b0 || sum0 !== 32'h0) begin
         n_fail++;
         $display("FAIL zero_len: done %b we %b sum %h expected 1 0 0", done0, mem0.o_Mem_We, sum0);
      end
      tick();
      n_tests++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_idle: done %b busy %b expected 0 0", done0, busy0);
      end
   endtask

   task automatic test_overrun();
      int unstable;
      pulse_start();
      send_word(32'h0000_0001);
      send_word(32'hAABB_CCDD);
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem0.o_Mem_We !== 1'b1 || mem0.o_Mem_Data !== 32'hAABB_CCDD || mem0.o_Mem_Addr !== 27'h0)
            unstable++;
         tick();
      end
      n_tests++;
      if (unstable !== 0) begin
         n_fail++;
         $display("FAIL write_stable: got %0d unstable cycles expected 0", unstable);
      end
      // Overrun coincident with ack: overrun wins
      ack = 1'b1;
      send_byte(8'hEE);
      ack = 1'b0;
      n_tests++;
      if (err0 !== 1'b1 || mem0.o_Mem_We !== 1'b0 || busy0 !== 1'b0 || sum0 !== 32'h0 || done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun: err %b we %b busy %b sum %h done %b expected 1 0 0 0 0", err0, mem0.o_Mem_We, busy0, sum0, done0);
      end
      send_word(32'h0102_0304);
      tick();
      n_tests++;
      if (err0 !== 1'b1 || busy0 !== 1'b0 || mem0.o_Mem_Data !== 32'hAABB_CCDD) begin
         n_fail++;
         $display("FAIL error_sticky: err %b busy %b data %h expected 1 0 aabbccdd", err0, busy0, mem0.o_Mem_Data);
      end
      pulse_start();
      n_tests++;
      if (err0 !== 1'b0 || busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL error_restart: err %b busy %b expected 0 1", err0, busy0);
      end
      send_word(32'h0000_0000);
      tick();
   endtask

   task automatic test_addr_wrap();
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'h0102_0304);
      n_tests++;
      if (mem1.o_Mem_We !== 1'b1 || mem1.o_Mem_Addr !== 27'h7FF_FFFF) begin
         n_fail++;
         $display("FAIL wrap_first: we %b addr %h expected 1 7ffffff", mem1.o_Mem_We, mem1.o_Mem_Addr);
      end
      do_ack();
      send_word(32'h1000_0001);
      n_tests++;
      if (mem1.o_Mem_We !== 1'b1 || mem1.o_Mem_Addr !== 27'h0 || mem0.o_Mem_Addr !== 27'h1) begin
         n_fail++;
         $display("FAIL wrap_second: we %b addr %h addr0 %h expected 1 0 1", mem1.o_Mem_We, mem1.o_Mem_Addr, mem0.o_Mem_Addr);
      end
      do_ack();
      n_tests++;
      if (done1 !== 1'b1 || sum1 !== 32'h1102_0305) begin
         n_fail++;
         $display("FAIL wrap_done: done %b sum %h expected 1 11020305", done1, sum1);
      end
      tick();
   endtask

   task automatic test_reset_mid_write();
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'h0000_0010);
      do_ack();
      send_word(32'h0000_0020);
      n_tests++;
      if (mem0.o_Mem_We !== 1'b1 || sum0 !== 32'h10) begin
         n_fail++;
         $display("FAIL pre_reset: we %b sum %h expected 1 10", mem0.o_Mem_We, sum0);
      end
      // Reset with a simultaneous ack and byte: reset dominates
      reset = 1'b1;
      ack   = 1'b1;
      rx_dv = 1'b1;
      tick();
      reset = 1'b0;
      ack   = 1'b0;
      rx_dv = 1'b0;
      n_tests++;
      if (mem0.o_Mem_We !== 1'b0 || busy0 !== 1'b0 || sum0 !== 32'h0 || err0 !== 1'b0 || mem0.o_Mem_Addr !== 27'h0 || mem0.o_Mem_Data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_write: we %b busy %b sum %h err %b addr %h data %h expected 0 0 0 0 0 0",
                  mem0.o_Mem_We, busy0, sum0, err0, mem0.o_Mem_Addr, mem0.o_Mem_Data);
      end
      tick();
      n_tests++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: busy %b done %b expected 0 0", busy0, done0);
      end
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_zero_len();
      test_overrun();
      test_addr_wrap();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
